// File: rtl/branch_target_buffer_dm.sv
// Direct-mapped branch target buffer: tag-matched entries with 2-bit saturating direction
// counters, a one-cycle registered lookup port, a resolution update port and a whole-table flush.
module branch_target_buffer_dm #(
    parameter int unsigned ADDR    = 32,
    parameter int unsigned N_ENTRY = 16,
    parameter int unsigned W_IDX   = $clog2(N_ENTRY),
    parameter int unsigned W_OFS   = 0,
    parameter int unsigned W_TAG   = ADDR - W_IDX - W_OFS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lk_v_i,
    input  logic [ADDR-1:0]   lk_pc_i,
    output logic              lk_v_o,
    output logic              hit_o,
    output logic              taken_o,
    output logic [ADDR-1:0]   target_o,
    input  logic              upd_v_i,
    input  logic [ADDR-1:0]   upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR-1:0]   upd_target_i,
    input  logic              flush_i,
    output logic [W_IDX:0]    valid_cnt_o
);

    logic [N_ENTRY-1:0] valid_q, valid_d;
    logic [W_TAG-1:0]   tag_q [N_ENTRY];
    logic [W_TAG-1:0]   tag_d [N_ENTRY];
    logic [ADDR-1:0]    tgt_q [N_ENTRY];
    logic [ADDR-1:0]    tgt_d [N_ENTRY];
    logic [1:0]         cnt_q [N_ENTRY];
    logic [1:0]         cnt_d [N_ENTRY];
    logic [W_IDX:0]     valid_cnt_q, valid_cnt_d;

    logic               lk_v_q, lk_v_d;
    logic               hit_q, hit_d;
    logic               taken_q, taken_d;
    logic [ADDR-1:0]    target_q, target_d;

    logic [W_IDX-1:0]   lk_idx, upd_idx;
    logic [W_TAG-1:0]   lk_tag, upd_tag;
    logic               lk_hit, upd_hit;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    assign lk_idx  = lk_pc_i[W_OFS +: W_IDX];
    assign lk_tag  = lk_pc_i[W_OFS + W_IDX +: W_TAG];
    assign upd_idx = upd_pc_i[W_OFS +: W_IDX];
    assign upd_tag = upd_pc_i[W_OFS + W_IDX +: W_TAG];

    // Qualify with the valid strobes first so undriven PCs never reach state.
    assign lk_hit  = lk_v_i && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign upd_hit = upd_v_i && valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Lookup reads the pre-update table: no bypass from the update port.
    always_comb begin
        lk_v_d   = lk_v_i;
        hit_d    = lk_hit;
        taken_d  = lk_hit && cnt_q[lk_idx][1];
        target_d = lk_hit ? tgt_q[lk_idx] : '0;
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (upd_v_i) begin
            if (upd_hit) begin
                if (upd_taken_i) begin
                    cnt_d[upd_idx] = sat_inc(cnt_q[upd_idx]);
                    tgt_d[upd_idx] = upd_target_i;
                end else begin
                    cnt_d[upd_idx] = sat_dec(cnt_q[upd_idx]);
                end
            end else if (upd_taken_i) begin
                // Conflict eviction: the new branch replaces any occupant.
                valid_d[upd_idx] = 1'b1;
                tag_d[upd_idx]   = upd_tag;
                tgt_d[upd_idx]   = upd_target_i;
                cnt_d[upd_idx]   = 2'b10;
            end
        end
    end

    always_comb begin
        valid_cnt_d = '0;
        for (int unsigned i = 0; i < N_ENTRY; i++) begin
            valid_cnt_d = valid_cnt_d + (W_IDX + 1)'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            valid_cnt_q <= '0;
            for (int unsigned i = 0; i < N_ENTRY; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= 2'b01;
            end
        end else begin
            valid_q     <= valid_d;
            valid_cnt_q <= valid_cnt_d;
            tag_q       <= tag_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lk_v_q   <= 1'b0;
            hit_q    <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            lk_v_q   <= lk_v_d;
            hit_q    <= hit_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    assign lk_v_o      = lk_v_q;
    assign hit_o       = hit_q;
    assign taken_o     = taken_q;
    assign target_o    = target_q;
    assign valid_cnt_o = valid_cnt_q;

endmodule

// File: tb/tb_branch_target_buffer_dm.sv
// Directed, table-driven bench for branch_target_buffer_dm (N_ENTRY=16, word-addressed PCs).
module tb_branch_target_buffer_dm;

    logic        clk;
    logic        reset;
    logic        lk_v_i;
    logic [31:0] lk_pc_i;
    logic        lk_v_o;
    logic        hit_o;
    logic        taken_o;
    logic [31:0] target_o;
    logic        upd_v_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        flush_i;
    logic [4:0]  valid_cnt_o;

    branch_target_buffer_dm #(
        .ADDR    (32),
        .N_ENTRY (16),
        .W_IDX   (4),
        .W_OFS   (0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lk_v_i       (lk_v_i),
        .lk_pc_i      (lk_pc_i),
        .lk_v_o       (lk_v_o),
        .hit_o        (hit_o),
        .taken_o      (taken_o),
        .target_o     (target_o),
        .upd_v_i      (upd_v_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_target_i (upd_target_i),
        .flush_i      (flush_i),
        .valid_cnt_o  (valid_cnt_o)
    );

    typedef struct {
        logic        lk_v;
        logic [31:0] lk_pc;
        logic        upd_v;
        logic [31:0] upd_pc;
        logic        upd_tk;
        logic [31:0] upd_tgt;
        logic        flush;
        logic        e_lkv;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;
    int   step_no;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic lkv, input logic [31:0] lkpc, input logic uv,
                                input logic [31:0] upc, input logic utk, input logic [31:0] utgt,
                                input logic fl, input logic elkv, input logic ehit,
                                input logic etk, input logic [31:0] etgt, input logic [4:0] ecnt);
        vec_t v;
        v.lk_v = lkv;   v.lk_pc = lkpc;  v.upd_v = uv;    v.upd_pc = upc;
        v.upd_tk = utk; v.upd_tgt = utgt; v.flush = fl;
        v.e_lkv = elkv; v.e_hit = ehit;  v.e_tk = etk;    v.e_tgt = etgt; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, step_no, act, exp);
        end
    endtask

    task automatic chk_outs(input logic elkv, input logic ehit, input logic etk,
                            input logic [31:0] etgt, input logic [4:0] ecnt);
        chk("lk_v_o", 32'(lk_v_o), 32'(elkv));
        chk("hit_o", 32'(hit_o), 32'(ehit));
        chk("taken_o", 32'(taken_o), 32'(etk));
        chk("target_o", target_o, etgt);
        chk("valid_cnt_o", 32'(valid_cnt_o), 32'(ecnt));
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        lk_v_i       = v.lk_v;
        lk_pc_i      = v.lk_pc;
        upd_v_i      = v.upd_v;
        upd_pc_i     = v.upd_pc;
        upd_taken_i  = v.upd_tk;
        upd_target_i = v.upd_tgt;
        flush_i      = v.flush;
        @(posedge clk);
        #1;
        chk_outs(v.e_lkv, v.e_hit, v.e_tk, v.e_tgt, v.e_cnt);
        step_no++;
    endtask

    initial begin
        n_vec = 0; n_err = 0; step_no = 0;
        reset = 1'b0;
        lk_v_i = 0; lk_pc_i = '0; upd_v_i = 0; upd_pc_i = '0;
        upd_taken_i = 0; upd_target_i = '0; flush_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs(0, 0, 0, 32'h0, 5'd0);
        @(negedge clk);
        reset = 1'b1;

        //       lkv lkpc       uv upc        tk utgt       fl  elkv hit tk etgt       cnt
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0,  1, 0, 0, 32'h0,   5'd0));
        vecs.push_back(mk(0, 32'h0,  1, 32'h40, 1, 32'h100, 0,  0, 0, 0, 32'h0,   5'd1));
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0,  1, 1, 1, 32'h100, 5'd1));
        vecs.push_back(mk(0, 32'h0,  1, 32'h40, 0, 32'h0,   0,  0, 0, 0, 32'h0,   5'd1));
        vecs.push_back(mk(0, 32'h0,  1, 32'h40, 0, 32'h0,   0,  0, 0, 0, 32'h0,   5'd1));
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0,  1, 1, 0, 32'h100, 5'd1));
        vecs.push_back(mk(1, 32'h40, 1, 32'h40, 0, 32'h0,   0,  1, 1, 0, 32'h100, 5'd1));
        vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h104, 0,  1, 1, 0, 32'h100, 5'd1));
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0,  1, 1, 0, 32'h104, 5'd1));
        vecs.push_back(mk(0, 32'h0,  1, 32'h40, 1, 32'h108, 0,  0, 0, 0, 32'h0,   5'd1));
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0,  1, 1, 1, 32'h108, 5'd1));
        vecs.push_back(mk(0, 32'h0,  1, 32'h40, 1, 32'h10C, 0,  0, 0, 0, 32'h0,   5'd1));
        vecs.push_back(mk(0, 32'h0,  1, 32'h40, 1, 32'h110, 0,  0, 0, 0, 32'h0,   5'd1));
        vecs.push_back(mk(1, 32'h40, 1, 32'h40, 0, 32'h0,   0,  1, 1, 1, 32'h110, 5'd1));
        vecs.push_back(mk(1, 32'h40, 1, 32'h40, 0, 32'h0,   0,  1, 1, 1, 32'h110, 5'd1));
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0,  1, 1, 0, 32'h110, 5'd1));
        vecs.push_back(mk(0, 32'h0,  1, 32'h44, 0, 32'h0,   0,  0, 0, 0, 32'h0,   5'd1));
        vecs.push_back(mk(1, 32'h44, 0, 32'h0,  0, 32'h0,   0,  1, 0, 0, 32'h0,   5'd1));
        vecs.push_back(mk(0, 32'h0,  1, 32'h50, 1, 32'h200, 0,  0, 0, 0, 32'h0,   5'd1));
        vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0,  1, 0, 0, 32'h0,   5'd1));
        vecs.push_back(mk(1, 32'h50, 0, 32'h0,  0, 32'h0,   0,  1, 1, 1, 32'h200, 5'd1));
        vecs.push_back(mk(1, 32'h44, 1, 32'h44, 1, 32'h300, 0,  1, 0, 0, 32'h0,   5'd2));
        vecs.push_back(mk(1, 32'h44, 0, 32'h0,  0, 32'h0,   0,  1, 1, 1, 32'h300, 5'd2));
        vecs.push_back(mk(1, 32'h1044, 0, 32'h0, 0, 32'h0,  0,  1, 0, 0, 32'h0,   5'd2));
        vecs.push_back(mk(1, 32'h44, 1, 32'h48, 1, 32'h400, 1,  1, 1, 1, 32'h300, 5'd0));
        vecs.push_back(mk(1, 32'h48, 0, 32'h0,  0, 32'h0,   0,  1, 0, 0, 32'h0,   5'd0));
        vecs.push_back(mk(1, 32'h44, 0, 32'h0,  0, 32'h0,   0,  1, 0, 0, 32'h0,   5'd0));

        foreach (vecs[k]) step(vecs[k]);

        // Fill every index, then flush with a concurrent taken update.
        for (int i = 0; i < 16; i++)
            step(mk(0, 32'h0, 1, 32'h80 + i, 1, 32'h1000 + i, 0, 0, 0, 0, 32'h0, 5'(i + 1)));
        for (int i = 0; i < 16; i++)
            step(mk(1, 32'h80 + i, 0, 32'h0, 0, 32'h0, 0, 1, 1, 1, 32'h1000 + i, 5'd16));
        step(mk(0, 32'h0, 1, 32'h95, 1, 32'h5555, 1, 0, 0, 0, 32'h0, 5'd0));
        for (int i = 0; i < 16; i++)
            step(mk(1, 32'h80 + i, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 5'd0));
        step(mk(1, 32'h95, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 5'd0));

        // Asynchronous reset between edges clears outputs at once.
        step(mk(0, 32'h0, 1, 32'h40, 1, 32'h777, 0, 0, 0, 0, 32'h0, 5'd1));
        step(mk(1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 1, 1, 1, 32'h777, 5'd1));
        reset = 1'b0;
        #1;
        chk_outs(0, 0, 0, 32'h0, 5'd0);
        @(negedge clk);
        reset = 1'b1;
        step(mk(1, 32'h40, 0, 32'h0, 0, 32'h0, 0, 1, 0, 0, 32'h0, 5'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
